branch_predictor: RTL and testbench
===================================

# branch_predictor

Per-PC two-bit saturating-counter branch predictor for the RISC-V core. It issues taken/not-taken predictions to fetch. It consumes the resolved outcome produced by the branch comparator in execute (eq/ne/lt/ge/ltu/geu, already reduced to one bit), trains its table, and raises a registered mispredict/redirect to fetch. It also keeps saturating branch and mispredict statistics counters.

## Interface
- ENTRIES, 64: number of counters; must be a power of two, minimum 2; IDX = log2(ENTRIES).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- pred_req  input  1  fetch requests a prediction for pred_pc this cycle.
- pred_pc  input  32  PC of the instruction being fetched.
- pred_valid  output  1  prediction result valid (1-cycle pulse).
- pred_taken  output  1  predicted direction; only meaningful while pred_valid=1.
- res_valid  input  1  a conditional branch resolved in execute this cycle.
- res_pc  input  32  PC of the resolved branch.
- res_taken  input  1  actual outcome from the branch comparator.
- res_pred_taken  input  1  prediction that was carried down the pipe with this branch.
- res_target  input  32  computed branch target (pc + B-immediate).
- mispredict  output  1  1-cycle pulse: the resolved branch disagreed with its prediction.
- redirect_pc  output  32  correct next PC; only meaningful while mispredict=1.
- stat_clear  input  1  synchronous clear of both statistics counters.
- stat_branches  output  32  count of resolved branches, saturating.
- stat_mispredicts  output  32  count of mispredicts, saturating.

## Operation
- Table: ENTRIES x 2-bit counters. Encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken. Predicted direction = counter bit 1.
- Index = pc[IDX+1:2]; PC bits [1:0] are ignored. There are no tags, so aliasing between PCs with the same index is permitted.
- Predict: when pred_req=1, the counter at index(pred_pc) is sampled. Next cycle pred_valid=1 and pred_taken=counter[1]. When pred_req=0, pred_valid=0 next cycle and pred_taken holds its last value.
- Train: when res_valid=1, the counter at index(res_pc) updates at the clock edge.
  - res_taken=1: increment, saturating at 11.
  - res_taken=0: decrement, saturating at 00.
- Mispredict: when res_valid=1 and res_taken != res_pred_taken, next cycle mispredict=1 and redirect_pc = res_taken ? res_target : res_pc + 32'd4. The +4 wraps modulo 2^32 (FFFFFFFC -> 00000000).
- When res_valid=0 or the directions agree, mispredict=0 next cycle and redirect_pc holds its last value.
- Statistics:
  - Each res_valid increments stat_branches.
  - Each res_valid with a mismatch increments stat_mispredicts.
  - Both counters hold at 32'hFFFFFFFF.
  - stat_clear=1 forces both to 0 at the next edge. Clear takes priority over an increment in the same cycle.
- Simultaneous predict and train to the same index: the prediction returns the pre-update counter value (read-before-write). The update still applies.
- The block has no FSM. Its state is the table, the output registers and the statistics counters.

## Timing
- Reset (rst_n low, asynchronous): every counter = 01. pred_valid=0, pred_taken=0, mispredict=0, redirect_pc=0, stat_branches=0, stat_mispredicts=0.
- Reset asserted mid-operation clears everything immediately; a pending pred_valid or mispredict pulse is lost. Normal operation resumes on the first edge after rst_n rises.
- Prediction latency: 1 cycle (pred_req at edge N -> pred_valid during cycle N+1). Back-to-back requests are accepted every cycle.
- Train latency: the counter is visible to a prediction requested on the cycle after res_valid.
- Mispredict/redirect latency: 1 cycle after res_valid. Pulses on consecutive resolves are independent.
- Statistics values are registered: updated at the same edge as the table.
- There is no backpressure on either port; every request is serviced.

## Test plan
- Reset then predict: pred_req with pred_pc=0x100 -> next cycle pred_valid=1, pred_taken=0 (counter 01).
- Training saturation on PC 0x200:
  - res_taken=1 three times -> the counter walks 01->10->11->11, and predictions read 1 after the first update.
  - Then res_taken=0 once -> the counter reads 10 and the prediction is still 1.
- Mispredict, taken case: res_pc=0x300, res_pred_taken=0, res_taken=1, res_target=0x340 -> next cycle mispredict=1, redirect_pc=0x340; stat_mispredicts=1, stat_branches=1.
- Mispredict, not-taken case with wrap: res_pc=0xFFFFFFFC, res_pred_taken=1, res_taken=0 -> redirect_pc=0x00000000.
- Same-index collision: with the counter at 01, present pred_req and res_valid (taken) on PC 0x400 in the same cycle -> pred_taken=0. A request on the following cycle returns 1.
- Statistics:
  - Preload stat_branches to 0xFFFFFFFF via repeated resolves (or force), then resolve again -> the value holds at 0xFFFFFFFF.
  - stat_clear together with res_valid and a mismatch -> both counters read 0.
  - Mid-test rst_n pulse -> all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Per-PC two-bit saturating-counter branch predictor with registered
// prediction, mispredict/redirect generation and saturating statistics.
module branch_predictor #(
   parameter int ENTRIES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pred_req,
   input  logic [31:0] pred_pc,
   output logic        pred_valid,
   output logic        pred_taken,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic        res_taken,
   input  logic        res_pred_taken,
   input  logic [31:0] res_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   input  logic        stat_clear,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);

   localparam int IDX = $clog2(ENTRIES);

   logic [1:0]     ctr_table [ENTRIES];
   logic [IDX-1:0] pred_idx;
   logic [IDX-1:0] res_idx;
   logic [1:0]     res_ctr;
   logic [1:0]     res_ctr_next;
   logic           res_mismatch;
   logic           unused_pc_bits;

   assign pred_idx     = pred_pc[IDX+1:2];
   assign res_idx      = res_pc[IDX+1:2];
   assign res_ctr      = ctr_table[res_idx];
   assign res_mismatch = res_valid && (res_taken != res_pred_taken);

   // Only the index bits of the fetch PC select a counter; there are no tags.
   assign unused_pc_bits = ^{pred_pc[31:IDX+2], pred_pc[1:0]};

   always_comb begin
      res_ctr_next = res_ctr;
      if (res_taken) begin
         if (res_ctr != 2'b11) res_ctr_next = res_ctr + 2'b01;
      end else begin
         if (res_ctr != 2'b00) res_ctr_next = res_ctr - 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= 2'b01;
      end else if (res_valid) begin
         ctr_table[res_idx] <= res_ctr_next;
      end
   end

   // Reads the table before this edge's training write lands (read-before-write).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
      end else begin
         pred_valid <= pred_req;
         if (pred_req) pred_taken <= ctr_table[pred_idx][1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict  <= 1'b0;
         redirect_pc <= 32'd0;
      end else begin
         mispredict <= res_mismatch;
         if (res_mismatch) redirect_pc <= res_taken ? res_target : res_pc + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= 32'd0;
         stat_mispredicts <= 32'd0;
      end else if (stat_clear) begin
         stat_branches    <= 32'd0;
         stat_mispredicts <= 32'd0;
      end else if (res_valid) begin
         if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
         if (res_mismatch && stat_mispredicts != 32'hFFFF_FFFF)
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: prediction, training saturation,
// mispredict/redirect, same-index collision, statistics and async reset.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pred_req;
   logic [31:0] pred_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic        res_valid;
   logic [31:0] res_pc;
   logic        res_taken;
   logic        res_pred_taken;
   logic [31:0] res_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        stat_clear;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_predictor #(.ENTRIES(64)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pred_req         (pred_req),
      .pred_pc          (pred_pc),
      .pred_valid       (pred_valid),
      .pred_taken       (pred_taken),
      .res_valid        (res_valid),
      .res_pc           (res_pc),
      .res_taken        (res_taken),
      .res_pred_taken   (res_pred_taken),
      .res_target       (res_target),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .stat_clear       (stat_clear),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic taken, input logic ptaken,
                          input logic [31:0] target);
      res_valid      = 1'b1;
      res_pc         = pc;
      res_taken      = taken;
      res_pred_taken = ptaken;
      res_target     = target;
   endtask

   task automatic predict_check(input string tag, input logic [31:0] pc, input logic exp);
      res_valid = 1'b0;
      pred_req  = 1'b1;
      pred_pc   = pc;
      cycle();
      check({tag, "_valid"}, {31'd0, pred_valid}, 32'd1);
      check(tag, {31'd0, pred_taken}, {31'd0, exp});
      pred_req = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; pred_req = 1'b0; pred_pc = '0; res_valid = 1'b0; res_pc = '0;
      res_taken = 1'b0; res_pred_taken = 1'b0; res_target = '0; stat_clear = 1'b0;
      #3;
      check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("rst_mispredict", {31'd0, mispredict}, 32'd0);
      check("rst_redirect",   redirect_pc, 32'd0);
      check("rst_branches",   stat_branches, 32'd0);
      check("rst_mispreds",   stat_mispredicts, 32'd0);
      #4 rst_n = 1'b1;
      cycle();

      // Fresh counter is weak not-taken
      predict_check("pred_0x100", 32'h100, 1'b0);
      cycle();
      check("idle_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("idle_pred_taken_hold", {31'd0, pred_taken}, 32'd0);

      // Walk 01->10->11->11, then back down 10, 01
      for (int i = 0; i < 3; i++) begin
         resolve(32'h200, 1'b1, 1'b1, 32'h280);
         cycle();
         check("agree_no_mispredict", {31'd0, mispredict}, 32'd0);
         predict_check("train_up", 32'h200, 1'b1);
      end
      check("branches_after_3", stat_branches, 32'd3);
      check("mispreds_after_3", stat_mispredicts, 32'd0);
      resolve(32'h200, 1'b0, 1'b0, 32'h280);
      cycle();
      predict_check("train_down_10", 32'h200, 1'b1);
      resolve(32'h200, 1'b0, 1'b0, 32'h280);
      cycle();
      predict_check("train_down_01", 32'h200, 1'b0);
      check("branches_after_5", stat_branches, 32'd5);

      stat_clear = 1'b1;
      cycle();
      stat_clear = 1'b0;
      check("clear_branches", stat_branches, 32'd0);
      check("clear_mispreds", stat_mispredicts, 32'd0);

      // Mispredict, taken
      resolve(32'h300, 1'b1, 1'b0, 32'h340);
      cycle();
      res_valid = 1'b0;
      check("mp_taken_pulse", {31'd0, mispredict}, 32'd1);
      check("mp_taken_redirect", redirect_pc, 32'h340);
      check("mp_taken_branches", stat_branches, 32'd1);
      check("mp_taken_mispreds", stat_mispredicts, 32'd1);
      cycle();
      check("mp_pulse_end", {31'd0, mispredict}, 32'd0);
      check("mp_redirect_hold", redirect_pc, 32'h340);

      // Mispredict, not-taken with +4 wrap, then an independent back-to-back one
      resolve(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234_5678);
      cycle();
      check("mp_wrap_pulse", {31'd0, mispredict}, 32'd1);
      check("mp_wrap_redirect", redirect_pc, 32'h0000_0000);
      resolve(32'h500, 1'b1, 1'b0, 32'h600);
      cycle();
      res_valid = 1'b0;
      check("mp_b2b_pulse", {31'd0, mispredict}, 32'd1);
      check("mp_b2b_redirect", redirect_pc, 32'h600);
      check("mp_b2b_branches", stat_branches, 32'd3);
      check("mp_b2b_mispreds", stat_mispredicts, 32'd3);

      // Async reset with a mispredict pulse still pending
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_mispredict", {31'd0, mispredict}, 32'd0);
      check("mid_rst_redirect", redirect_pc, 32'd0);
      check("mid_rst_branches", stat_branches, 32'd0);
      check("mid_rst_mispreds", stat_mispredicts, 32'd0);
      check("mid_rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      rst_n = 1'b1;
      cycle();

      // Index 0 had been trained to 11; reset restores 01 everywhere
      predict_check("post_rst_table", 32'h000, 1'b0);

      // Same-index predict and train: read-before-write
      pred_req = 1'b1;
      pred_pc  = 32'h400;
      resolve(32'h400, 1'b1, 1'b1, 32'h440);
      cycle();
      check("collide_valid", {31'd0, pred_valid}, 32'd1);
      check("collide_old_value", {31'd0, pred_taken}, 32'd0);
      predict_check("collide_next", 32'h400, 1'b1);
      predict_check("alias_0x100", 32'h100, 1'b1);

      // Statistics saturation
      force dut.stat_branches = 32'hFFFF_FFFE;
      #1;
      release dut.stat_branches;
      resolve(32'h404, 1'b1, 1'b1, 32'h0);
      cycle();
      check("sat_reach", stat_branches, 32'hFFFF_FFFF);
      cycle();
      res_valid = 1'b0;
      check("sat_hold", stat_branches, 32'hFFFF_FFFF);
      check("sat_mispreds", stat_mispredicts, 32'd0);

      // Clear wins over a same-cycle mispredicting resolve
      resolve(32'h408, 1'b1, 1'b0, 32'h800);
      stat_clear = 1'b1;
      cycle();
      res_valid  = 1'b0;
      stat_clear = 1'b0;
      check("clr_prio_branches", stat_branches, 32'd0);
      check("clr_prio_mispreds", stat_mispredicts, 32'd0);
      check("clr_prio_pulse", {31'd0, mispredict}, 32'd1);
      check("clr_prio_redirect", redirect_pc, 32'h800);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
